// File: rtl/button_conditioner.sv
// Two-channel push-button conditioner: synchronise, debounce, press strobe and
// optional hold-to-repeat stepping for each active-low button.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 100000,
  parameter int         REPEAT_DELAY    = 50000000,
  parameter int         REPEAT_PERIOD   = 10000000,
  parameter logic [1:0] REPEAT_EN       = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] buttons,
  output logic [1:0] pressed,
  output logic [1:0] press_pulse,
  output logic [1:0] step_pulse
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LIM = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] DLY_LIM = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LIM = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_REPEATING  = 2'd2
  } rep_state_t;

  for (genvar i = 0; i < 2; i++) begin : g_ch
    logic            r_sync1;
    logic            r_sync2;
    logic            r_pressed;
    logic            r_press_pulse;
    logic [DW-1:0]   r_db_cnt;
    rep_state_t      r_state;
    rep_state_t      w_state_nxt;
    logic [RW-1:0]   r_rep_cnt;
    logic [RW-1:0]   w_rep_cnt_nxt;
    logic            w_rep_step;
    logic            w_mismatch;
    logic            w_accept;

    // The counter runs up to DEBOUNCE_CYCLES and the toggle happens on the
    // following mismatching sample, giving DEBOUNCE_CYCLES+2 edges of latency.
    assign w_mismatch = (~r_sync2) ^ r_pressed;
    assign w_accept   = w_mismatch && (r_db_cnt == DEB_LIM);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync1       <= 1'b1;
        r_sync2       <= 1'b1;
        r_pressed     <= 1'b0;
        r_press_pulse <= 1'b0;
        r_db_cnt      <= '0;
      end else begin
        r_sync1       <= buttons[i];
        r_sync2       <= r_sync1;
        r_press_pulse <= w_accept & ~r_pressed;
        if (!w_mismatch) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_db_cnt  <= '0;
          r_pressed <= ~r_pressed;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= S_IDLE;
        r_rep_cnt <= '0;
      end else begin
        r_state   <= w_state_nxt;
        r_rep_cnt <= w_rep_cnt_nxt;
      end
    end

    // A release overrides every state, so no step can leak out after it.
    always_comb begin
      w_state_nxt   = r_state;
      w_rep_cnt_nxt = r_rep_cnt;
      w_rep_step    = 1'b0;
      if (!r_pressed) begin
        w_state_nxt   = S_IDLE;
        w_rep_cnt_nxt = '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (r_press_pulse && REPEAT_EN[i]) begin
              w_state_nxt   = S_WAIT_FIRST;
              w_rep_cnt_nxt = '0;
            end
          end
          S_WAIT_FIRST: begin
            if (r_rep_cnt == DLY_LIM) begin
              w_rep_step    = 1'b1;
              w_state_nxt   = S_REPEATING;
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + RW'(1);
            end
          end
          S_REPEATING: begin
            if (r_rep_cnt == PER_LIM) begin
              w_rep_step    = 1'b1;
              w_rep_cnt_nxt = '0;
            end else begin
              w_rep_cnt_nxt = r_rep_cnt + RW'(1);
            end
          end
          default: begin
            w_state_nxt   = S_IDLE;
            w_rep_cnt_nxt = '0;
          end
        endcase
      end
    end

    assign pressed[i]     = r_pressed;
    assign press_pulse[i] = r_press_pulse;
    assign step_pulse[i]  = r_press_pulse | w_rep_step;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// all checked cycle by cycle against a sample-window / press-age reference model.
module tb_button_conditioner;

  localparam int         DEB    = 4;
  localparam int         DELAY  = 10;
  localparam int         PERIOD = 5;
  localparam logic [1:0] EN     = 2'b01;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] buttons;
  logic [1:0] pressed;
  logic [1:0] press_pulse;
  logic [1:0] step_pulse;

  int n_cmp = 0;
  int n_err = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_PERIOD  (PERIOD),
    .REPEAT_EN      (EN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buttons    (buttons),
    .pressed    (pressed),
    .press_pulse(press_pulse),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last DEB+1 synchronised
  // samples all disagree with it; steps follow from the age of the press.
  logic [1:0] m_s1, m_s2, m_pressed, m_pp, m_step;
  logic [1:0] m_hist [0:DEB];
  int         m_age  [2];

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11;
    m_pressed = 2'b00; m_pp = 2'b00; m_step = 2'b00;
    for (int k = 0; k <= DEB; k++) m_hist[k] = 2'b00;
    m_age[0] = 0; m_age[1] = 0;
  endtask

  task automatic model_edge(input logic [1:0] b);
    bit all_diff;
    for (int k = DEB; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = ~m_s2;
    m_s2 = m_s1;
    m_s1 = b;
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k <= DEB; k++)
        if (m_hist[k][ch] == m_pressed[ch]) all_diff = 1'b0;
      m_pp[ch] = all_diff & ~m_pressed[ch];
      if (all_diff) m_pressed[ch] = ~m_pressed[ch];
      if (m_pp[ch]) begin
        m_age[ch]  = 0;
        m_step[ch] = 1'b1;
      end else if (m_pressed[ch]) begin
        m_age[ch]++;
        m_step[ch] = EN[ch] && (m_age[ch] >= DELAY) && (((m_age[ch] - DELAY) % PERIOD) == 0);
      end else begin
        m_step[ch] = 1'b0;
      end
    end
  endtask

  task automatic tick(input logic [1:0] b);
    buttons = b;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(b);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    buttons = 2'b11;
    model_reset();
    #2;
    for (int k = 0; k < 3; k++) begin
      tick(2'b11);
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== 6'b0) begin
        n_err++;
        $display("FAIL reset_outputs k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, 6'b0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(2'b11);
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL post_reset k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
  endtask

  task automatic test_clean_press();
    int first_p = -1;
    int n_pp = 0;
    for (int k = 0; k < 24; k++) begin
      tick(k < 12 ? 2'b10 : 2'b11);
      if (pressed[0] && first_p < 0) first_p = k;
      if (press_pulse[0]) n_pp++;
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL clean_press k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (first_p !== DEB + 2) begin
      n_err++;
      $display("FAIL clean_press_latency got %0d want %0d", first_p, DEB + 2);
    end
    n_cmp++;
    if (n_pp !== 1) begin
      n_err++;
      $display("FAIL clean_press_pulse_count got %0d want 1", n_pp);
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat = 6'b100011;
    int act = 0;
    for (int k = 0; k < 16; k++) begin
      tick(k < 6 ? {1'b1, pat[k]} : 2'b11);
      if ((pressed | press_pulse | step_pulse) != 2'b00) act++;
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL bounce k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (act !== 0) begin
      n_err++;
      $display("FAIL bounce_activity got %0d active cycles want 0", act);
    end
  endtask

  task automatic test_hold_ch0();
    int n_step = 0;
    int fall = -1;
    logic prev = 1'b0;
    for (int k = 0; k < 56; k++) begin
      tick(k < 40 ? 2'b10 : 2'b11);
      if (step_pulse[0]) n_step++;
      if (prev && !pressed[0] && fall < 0) fall = k;
      prev = pressed[0];
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL hold_ch0 k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (n_step !== 7) begin
      n_err++;
      $display("FAIL hold_ch0_steps got %0d want 7", n_step);
    end
    n_cmp++;
    if (fall !== 40 + DEB + 2) begin
      n_err++;
      $display("FAIL hold_ch0_release got %0d want %0d", fall, 40 + DEB + 2);
    end
  endtask

  task automatic test_hold_ch1();
    int n_step = 0;
    int n_held = 0;
    for (int k = 0; k < 52; k++) begin
      tick(k < 40 ? 2'b01 : 2'b11);
      if (step_pulse[1]) n_step++;
      if (pressed[1]) n_held++;
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL hold_ch1 k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (n_step !== 1 || n_held !== 40) begin
      n_err++;
      $display("FAIL hold_ch1_counts got steps=%0d held=%0d want steps=1 held=40", n_step, n_held);
    end
  endtask

  task automatic test_reset_mid_hold();
    int pp_at = -1;
    for (int k = 0; k <= DEB + 2 + 12; k++) begin
      tick(2'b10);
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL rst_hold_pre k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({pressed, press_pulse, step_pulse} !== 6'b0) begin
      n_err++;
      $display("FAIL rst_async got %b want %b", {pressed, press_pulse, step_pulse}, 6'b0);
    end
    for (int k = 0; k < 3; k++) begin
      tick(2'b10);
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== 6'b0) begin
        n_err++;
        $display("FAIL rst_hold_during k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, 6'b0);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick(k < 12 ? 2'b10 : 2'b11);
      if (press_pulse[0] && pp_at < 0) pp_at = k;
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL rst_hold_post k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (pp_at !== DEB + 2) begin
      n_err++;
      $display("FAIL rst_hold_fresh_press got %0d want %0d", pp_at, DEB + 2);
    end
  endtask

  task automatic test_simultaneous();
    int both = 0;
    int s0 = 0;
    int s1 = 0;
    for (int k = 0; k < 42; k++) begin
      tick(k < 30 ? 2'b00 : 2'b11);
      if (press_pulse == 2'b11) both++;
      if (step_pulse[0]) s0++;
      if (step_pulse[1]) s1++;
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL simultaneous k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
    n_cmp++;
    if (both !== 1 || s0 !== 5 || s1 !== 1) begin
      n_err++;
      $display("FAIL simultaneous_counts got both=%0d s0=%0d s1=%0d want 1 5 1", both, s0, s1);
    end
  endtask

  task automatic test_random();
    logic [1:0] b = 2'b11;
    int run [2];
    run[0] = 1; run[1] = 1;
    for (int k = 0; k < 1600; k++) begin
      for (int ch = 0; ch < 2; ch++) begin
        run[ch]--;
        if (run[ch] <= 0) begin
          b[ch] = ~b[ch];
          run[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
        end
      end
      tick(k < 1580 ? b : 2'b11);
      n_cmp++;
      if ({pressed, press_pulse, step_pulse} !== {m_pressed, m_pp, m_step}) begin
        n_err++;
        $display("FAIL random k=%0d got %b want %b", k, {pressed, press_pulse, step_pulse}, {m_pressed, m_pp, m_step});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_hold_ch0();
    test_hold_ch1();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
